// File: rtl/chdr_dechunker_multi.sv
// Strips fixed-size chunk framing from a CHDR stream: each frame of F words carries one packet
// whose byte length sits in the header; words past the packet end are consumed and dropped.
module chdr_dechunker_multi #(
   parameter int unsigned WIDTH       = 64,
   parameter int unsigned LEN_LSB     = 16,
   parameter int unsigned ERR_RECOVER = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [15:0]      frame_size,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic             error,
   output logic [15:0]      err_count
);

   localparam int unsigned BPW_LOG2 = $clog2(WIDTH / 8);
   localparam logic [16:0] BPW_M1   = 17'(WIDTH / 8 - 1);

   typedef enum logic [1:0] {ST_HEADER, ST_PAYLOAD, ST_PADDING, ST_ERROR} state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [15:0] r_frame;
   logic [16:0] r_words;
   logic        r_error;
   logic [15:0] r_err_count;

   logic [15:0] w_len;
   logic [16:0] w_words_raw;
   logic [16:0] w_words;
   logic [15:0] w_frame;
   logic        w_oversize;
   logic        w_acc;
   logic [15:0] w_cnt_nxt;
   logic        w_last_pay;
   logic        w_last_frm;
   logic        w_pass;
   logic        w_tlast_sel;

   // Packet length rounded up to whole bus words; 17 bits so 0xFFFF bytes cannot wrap.
   assign w_len       = i_tdata[LEN_LSB+15:LEN_LSB];
   assign w_words_raw = ({1'b0, w_len} + BPW_M1) >> BPW_LOG2;
   assign w_words     = (w_words_raw == 17'd0) ? 17'd1 : w_words_raw;
   assign w_frame     = (frame_size == 16'd0) ? 16'd1 : frame_size;
   assign w_oversize  = w_words > {1'b0, w_frame};

   assign w_acc      = i_tvalid & i_tready;
   assign w_cnt_nxt  = r_cnt + 16'd1;
   assign w_last_pay = ({1'b0, r_cnt} == (r_words - 17'd1));
   assign w_last_frm = (w_cnt_nxt == r_frame);

   assign o_tdata   = i_tdata;
   assign error     = r_error;
   assign err_count = r_err_count;

   always_comb begin
      w_pass = (r_state == ST_PAYLOAD) || ((r_state == ST_HEADER) && !w_oversize);
      if (reset || clear) begin
         o_tvalid = 1'b0;
         i_tready = 1'b0;
      end else if (w_pass) begin
         o_tvalid = i_tvalid;
         i_tready = o_tready;
      end else begin
         o_tvalid = 1'b0;
         i_tready = 1'b1;
      end
      w_tlast_sel = (r_state == ST_HEADER) ? (w_words == 17'd1) : w_last_pay;
      o_tlast     = o_tvalid & w_tlast_sel;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_HEADER;
         r_cnt       <= 16'd0;
         r_frame     <= 16'd1;
         r_words     <= 17'd1;
         r_error     <= 1'b0;
         r_err_count <= 16'd0;
      end else if (clear) begin
         r_state     <= ST_HEADER;
         r_cnt       <= 16'd0;
         r_frame     <= 16'd1;
         r_words     <= 17'd1;
         r_error     <= 1'b0;
         r_err_count <= 16'd0;
      end else if (w_acc) begin
         unique case (r_state)
            ST_HEADER: begin
               r_frame <= w_frame;
               r_words <= w_words;
               if (w_oversize) begin
                  r_error <= 1'b1;
                  if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                  // A one-word frame has nothing left to discard when recovering.
                  if ((ERR_RECOVER != 0) && (w_frame == 16'd1)) begin
                     r_state <= ST_HEADER;
                     r_cnt   <= 16'd0;
                  end else begin
                     r_state <= ST_ERROR;
                     r_cnt   <= 16'd1;
                  end
               end else if (w_words > 17'd1) begin
                  r_state <= ST_PAYLOAD;
                  r_cnt   <= 16'd1;
               end else if (w_frame > 16'd1) begin
                  r_state <= ST_PADDING;
                  r_cnt   <= 16'd1;
               end else begin
                  r_state <= ST_HEADER;
                  r_cnt   <= 16'd0;
               end
            end
            ST_PAYLOAD: begin
               if (w_last_pay && (r_words >= {1'b0, r_frame})) begin
                  r_state <= ST_HEADER;
                  r_cnt   <= 16'd0;
               end else begin
                  if (w_last_pay) r_state <= ST_PADDING;
                  r_cnt <= w_cnt_nxt;
               end
            end
            ST_PADDING: begin
               if (w_last_frm) begin
                  r_state <= ST_HEADER;
                  r_cnt   <= 16'd0;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            ST_ERROR: begin
               if (ERR_RECOVER != 0) begin
                  if (w_last_frm) begin
                     r_state <= ST_HEADER;
                     r_cnt   <= 16'd0;
                  end else begin
                     r_cnt <= w_cnt_nxt;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chdr_dechunker_multi.sv
// Drives three dechunker variants (64b sticky, 64b recovering, 128b sticky) with the same beats
// and compares each against a frame-level reference model.
module tb_chdr_dechunker_multi;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, clear, o_rdy, pend, rnd_rdy;
   logic [15:0]  frame_size;
   logic [127:0] din;
   logic [2:0]   done, vld, rdy, ov, ol, er;
   logic [15:0]  ec [3];
   logic [63:0]  od0, od1;
   logic [127:0] od2;

   assign vld = {3{pend}} & ~done;

   chdr_dechunker_multi #(.WIDTH(64), .LEN_LSB(16), .ERR_RECOVER(0)) u_dut0 (
      .clk(clk), .reset(reset), .clear(clear), .frame_size(frame_size),
      .i_tdata(din[63:0]), .i_tvalid(vld[0]), .i_tready(rdy[0]),
      .o_tdata(od0), .o_tlast(ol[0]), .o_tvalid(ov[0]), .o_tready(o_rdy),
      .error(er[0]), .err_count(ec[0]));

   chdr_dechunker_multi #(.WIDTH(64), .LEN_LSB(16), .ERR_RECOVER(1)) u_dut1 (
      .clk(clk), .reset(reset), .clear(clear), .frame_size(frame_size),
      .i_tdata(din[63:0]), .i_tvalid(vld[1]), .i_tready(rdy[1]),
      .o_tdata(od1), .o_tlast(ol[1]), .o_tvalid(ov[1]), .o_tready(o_rdy),
      .error(er[1]), .err_count(ec[1]));

   chdr_dechunker_multi #(.WIDTH(128), .LEN_LSB(16), .ERR_RECOVER(0)) u_dut2 (
      .clk(clk), .reset(reset), .clear(clear), .frame_size(frame_size),
      .i_tdata(din), .i_tvalid(vld[2]), .i_tready(rdy[2]),
      .o_tdata(od2), .o_tlast(ol[2]), .o_tvalid(ov[2]), .o_tready(o_rdy),
      .error(er[2]), .err_count(ec[2]));

   int n_chk = 0;
   int n_err = 0;
   int acc_cnt [3];
   logic [127:0] sent [$];
   logic [128:0] got0 [$];
   logic [128:0] got1 [$];
   logic [128:0] got2 [$];
   logic [128:0] exp_q [$];
   logic         exp_err;
   int           exp_ec;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int got_size(input int k);
      case (k)
         0:       return got0.size();
         1:       return got1.size();
         default: return got2.size();
      endcase
   endfunction

   function automatic logic [128:0] got_at(input int k, input int i);
      case (k)
         0:       return got0[i];
         1:       return got1[i];
         default: return got2[i];
      endcase
   endfunction

   function automatic logic [127:0] hdr(input int len);
      logic [127:0] h;
      h = {$urandom, $urandom, $urandom, $urandom};
      h[31:16] = 16'(len);
      return h;
   endfunction

   // Offer one beat to all three DUTs; each takes it exactly once.
   task automatic send(input logic [127:0] d);
      logic [2:0] acc_m;
      din  = d;
      done = 3'b000;
      pend = 1'b1;
      for (int c = 0; c < 64 && done != 3'b111; c++) begin
         o_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         acc_m = vld & rdy;
         if (ov[0] && o_rdy) got0.push_back({ol[0], 64'd0, od0});
         if (ov[1] && o_rdy) got1.push_back({ol[1], 64'd0, od1});
         if (ov[2] && o_rdy) got2.push_back({ol[2], od2});
         @(posedge clk);
         #1;
         done = done | acc_m;
         for (int k = 0; k < 3; k++) if (acc_m[k]) acc_cnt[k]++;
      end
      if (done != 3'b111) chk("send_timeout", 128'(done), 128'(3'b111));
      sent.push_back(d);
      pend = 1'b0;
      done = 3'b000;
   endtask

   task automatic send_frame(input int len, input int fe);
      send(hdr(len));
      for (int j = 1; j < fe; j++) send({$urandom, $urandom, $urandom, $urandom});
   endtask

   task automatic start_test(input logic [15:0] fs);
      clear      = 1'b1;
      frame_size = fs;
      @(posedge clk);
      #1;
      clear = 1'b0;
      sent.delete();
      got0.delete();
      got1.delete();
      got2.delete();
      for (int k = 0; k < 3; k++) acc_cnt[k] = 0;
   endtask

   // Frame-level model: walk the sent beats in steps of F and emit the leading W words.
   task automatic build_exp(input int k);
      int           bpw, fe, i, w, len;
      bit           sticky;
      logic [127:0] mask;
      bpw     = (k == 2) ? 16 : 8;
      mask    = (k == 2) ? {128{1'b1}} : {64'd0, {64{1'b1}}};
      fe      = (frame_size == 16'd0) ? 1 : int'(frame_size);
      exp_q.delete();
      exp_err = 1'b0;
      exp_ec  = 0;
      sticky  = 1'b0;
      i       = 0;
      while (i < sent.size() && !sticky) begin
         len = int'(sent[i][31:16]);
         w   = (len + bpw - 1) / bpw;
         if (w == 0) w = 1;
         if (w > fe) begin
            exp_err = 1'b1;
            exp_ec++;
            if (k != 1) sticky = 1'b1;
         end else begin
            for (int j = 0; j < w; j++)
               if (i + j < sent.size()) exp_q.push_back({(j == w - 1), sent[i+j] & mask});
         end
         i += fe;
      end
   endtask

   task automatic verify(input string name);
      logic [128:0] g;
      int n;
      for (int k = 0; k < 3; k++) begin
         build_exp(k);
         chk($sformatf("%s_d%0d_words", name, k), 128'(got_size(k)), 128'(exp_q.size()));
         n = (got_size(k) < exp_q.size()) ? got_size(k) : exp_q.size();
         for (int i = 0; i < n; i++) begin
            g = got_at(k, i);
            chk($sformatf("%s_d%0d_data%0d", name, k, i), g[127:0], exp_q[i][127:0]);
            chk($sformatf("%s_d%0d_last%0d", name, k, i), 128'(g[128]), 128'(exp_q[i][128]));
         end
         chk($sformatf("%s_d%0d_error", name, k), 128'(er[k]), 128'(exp_err));
         chk($sformatf("%s_d%0d_errcnt", name, k), 128'(ec[k]), 128'(exp_ec));
         chk($sformatf("%s_d%0d_accepted", name, k), 128'(acc_cnt[k]), 128'(sent.size()));
      end
   endtask

   initial begin
      logic [128:0] g;
      int fs, fe, len;
      reset      = 1'b1;
      clear      = 1'b0;
      pend       = 1'b0;
      done       = 3'b000;
      o_rdy      = 1'b1;
      rnd_rdy    = 1'b0;
      frame_size = 16'd8;
      din        = '0;
      #12;
      chk("rst_i_tready", 128'(rdy), 128'(0));
      chk("rst_o_tvalid", 128'(ov), 128'(0));
      chk("rst_o_tlast", 128'(ol), 128'(0));
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_error%0d", k), 128'(er[k]), 128'(0));
         chk($sformatf("rst_errcnt%0d", k), 128'(ec[k]), 128'(0));
      end

      // One 64b packet of 4 words inside an 8-word frame.
      start_test(16'd8);
      send_frame(32, 8);
      verify("t_len32");
      chk("t_len32_words", 128'(got_size(0)), 128'(4));
      g = got_at(0, 3);
      chk("t_len32_tlast4", 128'(g[128]), 128'(1));
      chk("t_len32_acc", 128'(acc_cnt[0]), 128'(8));

      // Oversize header, then a valid frame.
      start_test(16'd10);
      send_frame(88, 10);
      send_frame(16, 10);
      verify("t_over");
      chk("t_over_words0", 128'(got_size(0)), 128'(0));
      chk("t_over_err0", 128'(er[0]), 128'(1));

      // Recovery after an oversize frame.
      start_test(16'd10);
      send_frame(88, 10);
      send_frame(80, 10);
      verify("t_recover");
      chk("t_recover_words1", 128'(got_size(1)), 128'(10));
      g = got_at(1, 9);
      chk("t_recover_tlast", 128'(g[128]), 128'(1));
      chk("t_recover_ecnt1", 128'(ec[1]), 128'(1));

      // 128b: W=3 in F=4, then len=0.
      start_test(16'd4);
      send_frame(40, 4);
      send_frame(0, 4);
      verify("t_w128");
      chk("t_w128_words2", 128'(got_size(2)), 128'(4));
      g = got_at(2, 3);
      chk("t_w128_len0_last", 128'(g[128]), 128'(1));

      // Backpressure across four packets.
      rnd_rdy = 1'b1;
      start_test(16'd8);
      for (int f = 1; f <= 4; f++) send_frame(8 * f, 8);
      verify("t_bp");
      chk("t_bp_words0", 128'(got_size(0)), 128'(10));
      g = got_at(0, 9);
      chk("t_bp_lastdata", g[127:0], sent[27] & {64'd0, {64{1'b1}}});

      // Single-word frames.
      start_test(16'd1);
      for (int b = 0; b < 5; b++) send_frame(8, 1);
      send_frame(16, 1);
      send_frame(8, 1);
      send_frame(8, 1);
      verify("t_f1");
      chk("t_f1_err0", 128'(er[0]), 128'(1));

      // Randomized frame sizes and lengths, including frame_size=0.
      for (int it = 0; it < 20; it++) begin
         fs = $urandom_range(0, 6);
         fe = (fs == 0) ? 1 : fs;
         start_test(16'(fs));
         for (int f = 0; f < 3; f++) begin
            len = ($urandom_range(0, 1) == 1) ? $urandom_range(0, fe * 8)
                                              : $urandom_range(0, fe * 16 + 8);
            send_frame(len, fe);
         end
         verify($sformatf("rnd%0d", it));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
